// File: rtl/id_stage_pipe.sv
// Decode stage: IF/ID register, register file, immediate extension and load-use hazard; 1-cycle fetch-to-decode latency.
// IF/ID holds on stall_D or hazard_D and flush_D wins; WB->ID same-cycle bypass only when ID_WB_BYPASS_EN is defined.
module id_stage_pipe #(
  parameter int DW = 32,
  parameter int RA = 5,
  parameter int JW = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] instr_F,
  input  logic [DW-1:0] pc_F,
  input  logic          valid_F,
  input  logic          stall_D,
  input  logic          flush_D,
  input  logic          reg_we_W,
  input  logic [RA-1:0] reg_waddr_W,
  input  logic [DW-1:0] reg_wdata_W,
  input  logic          load_E,
  input  logic [RA-1:0] rt_E,
  output logic [DW-1:0] instr_D,
  output logic [DW-1:0] pc_D,
  output logic          valid_D,
  output logic [RA-1:0] rs_addr_D,
  output logic [RA-1:0] rt_addr_D,
  output logic [RA-1:0] rd_addr_D,
  output logic [DW-1:0] rs_data_D,
  output logic [DW-1:0] rt_data_D,
  output logic [DW-1:0] imm_ext_D,
  output logic [JW-1:0] low26_D,
  output logic          hazard_D
);

  localparam int NREG = 2 ** RA;

  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];

  logic [4:0]  rs_fld, rt_fld, rd_fld;
  logic [5:0]  opcode;
  logic [15:0] imm16;
  logic        zext;
  logic        wb_wr;

  // IF/ID register: flush beats hold, hold beats load.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_D) begin
      instr_d = '0;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (!(stall_D || hazard_D)) begin
      instr_d = valid_F ? instr_F : '0;
      pc_d    = pc_F;
      valid_d = valid_F;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Register file writes ignore IF/ID state entirely.
  assign wb_wr = reg_we_W && (reg_waddr_W != '0);

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wb_wr) begin
      rf_d[reg_waddr_W] = reg_wdata_W;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign rs_fld    = instr_q[25:21];
  assign rt_fld    = instr_q[20:16];
  assign rd_fld    = instr_q[15:11];
  assign rs_addr_D = RA'(rs_fld);
  assign rt_addr_D = RA'(rt_fld);
  assign rd_addr_D = RA'(rd_fld);

  always_comb begin
    rs_data_D = (rs_addr_D == '0) ? '0 : rf_q[rs_addr_D];
    rt_data_D = (rt_addr_D == '0) ? '0 : rf_q[rt_addr_D];
`ifdef ID_WB_BYPASS_EN
    if (wb_wr && (reg_waddr_W == rs_addr_D)) rs_data_D = reg_wdata_W;
    if (wb_wr && (reg_waddr_W == rt_addr_D)) rt_data_D = reg_wdata_W;
`endif
  end

  // ANDI/ORI/XORI take a zero-extended immediate; everything else sign-extends.
  assign opcode = instr_q[31:26];
  assign imm16  = instr_q[15:0];
  assign zext   = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);

  always_comb begin
    if (zext) imm_ext_D = {{(DW-16){1'b0}}, imm16};
    else      imm_ext_D = {{(DW-16){imm16[15]}}, imm16};
  end

  assign low26_D = instr_q[JW-1:0];

  assign hazard_D = valid_q && load_E && (rt_E != '0) &&
                    ((rt_E == rs_addr_D) || (rt_E == rt_addr_D));

  assign instr_D = instr_q;
  assign pc_D    = pc_q;
  assign valid_D = valid_q && !hazard_D;

endmodule
